// File: rtl/display_pkg.sv
// Shared types and constants for the display scheduler: FSM states, limits and the
// seven-segment lookup.
package display_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CONV   = 2'd1,
        UPDATE = 2'd2
    } state_t;

    localparam int unsigned DEC_MAX    = 999999;
    localparam int unsigned NUM_DIGITS = 6;
    localparam logic [6:0]  SEG_BLANK  = 7'h7F;

    // Active-low segments, bit 6 = g ... bit 0 = a.
    function automatic logic [6:0] seg_code(input logic [3:0] digit);
        logic [6:0] code;
        case (digit)
            4'h0:    code = 7'b1000000;
            4'h1:    code = 7'b1111001;
            4'h2:    code = 7'b0100100;
            4'h3:    code = 7'b0110000;
            4'h4:    code = 7'b0011001;
            4'h5:    code = 7'b0010010;
            4'h6:    code = 7'b0000010;
            4'h7:    code = 7'b1111000;
            4'h8:    code = 7'b0000000;
            4'h9:    code = 7'b0010000;
            4'hA:    code = 7'b0001000;
            4'hB:    code = 7'b0000011;
            4'hC:    code = 7'b1000110;
            4'hD:    code = 7'b0100001;
            4'hE:    code = 7'b0000110;
            default: code = 7'b0001110;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/display_scheduler_if.sv
// Requester-side valid/ready bundle: one value, mode bit and grant per requester.
interface display_scheduler_if #(
    parameter int unsigned NREQ = 2
);
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0][31:0] req_data;
    logic [NREQ-1:0]       req_dec;
    logic [NREQ-1:0]       req_ready;

    modport master (output req_valid, output req_data, output req_dec, input req_ready);
    modport slave  (input req_valid, input req_data, input req_dec, output req_ready);
endinterface

// File: rtl/seg7_decode.sv
// One hex digit to active-low seven-segment pattern, with a blank override.
module seg7_decode
    import display_pkg::*;
(
    input  logic [3:0] digit,
    input  logic       blank,
    output logic [6:0] seg
);

    assign seg = blank ? SEG_BLANK : seg_code(digit);

endmodule

// File: rtl/display_scheduler.sv
// Arbitrates two requesters onto a six-digit display; decimal values go through a
// serial double-dabble converter and all digits are committed on a single edge.
module display_scheduler
    import display_pkg::*;
#(
    parameter int unsigned NREQ      = 2,
    parameter int unsigned CONV_BITS = 20
) (
    input  logic                 clk,
    input  logic                 rst_n,
    display_scheduler_if.slave   req,
    input  logic                 lz_blank,
    output logic                 busy,
    output logic                 overflow,
    output logic [6:0]           HEX0,
    output logic [6:0]           HEX1,
    output logic [6:0]           HEX2,
    output logic [6:0]           HEX3,
    output logic [6:0]           HEX4,
    output logic [6:0]           HEX5
);

    state_t                      state_q, state_d;
    logic                        last_grant_q, last_grant_d;
    logic [23:0]                 bcd_q, bcd_d, bcd_adj;
    logic [CONV_BITS-1:0]        bin_q, bin_d;
    logic [4:0]                  cnt_q, cnt_d;
    logic                        ovf_next_q, ovf_next_d;
    logic                        lz_q, lz_d;
    logic [NUM_DIGITS-1:0][6:0]  hex_q, hex_d;
    logic                        overflow_q, overflow_d;

    logic [NREQ-1:0]             grant;
    logic [31:0]                 sel_data;
    logic                        sel_dec;
    logic [NUM_DIGITS-1:0]       blank;
    logic [NUM_DIGITS-1:0][6:0]  seg;

    // Grant only in IDLE and never while reset is held.
    always_comb begin
        grant = '0;
        if (state_q == IDLE && rst_n) begin
            case (req.req_valid)
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
                2'b11:   grant = last_grant_q ? 2'b01 : 2'b10;
                default: grant = '0;
            endcase
        end
    end

    assign req.req_ready = grant;
    assign sel_data      = req.req_data[grant[1]];
    assign sel_dec       = req.req_dec[grant[1]];
    assign busy          = (state_q != IDLE);

    always_comb begin
        bcd_adj = bcd_q;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (bcd_q[4*k +: 4] >= 4'd5) bcd_adj[4*k +: 4] = bcd_q[4*k +: 4] + 4'd3;
        end
    end

    // A digit is blank when it and every more significant digit are zero; HEX0 never is.
    always_comb begin
        blank                 = '0;
        blank[NUM_DIGITS-1]   = lz_q && (bcd_q[23:20] == 4'd0);
        for (int k = NUM_DIGITS - 2; k >= 1; k--) begin
            blank[k] = blank[k+1] && (bcd_q[4*k +: 4] == 4'd0);
        end
    end

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : gen_dec
        seg7_decode u_seg7_decode (
            .digit (bcd_q[4*g +: 4]),
            .blank (blank[g]),
            .seg   (seg[g])
        );
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        bcd_d        = bcd_q;
        bin_d        = bin_q;
        cnt_d        = cnt_q;
        ovf_next_d   = ovf_next_q;
        lz_d         = lz_q;
        hex_d        = hex_q;
        overflow_d   = overflow_q;
        case (state_q)
            IDLE: begin
                if (|grant) begin
                    last_grant_d = grant[1];
                    lz_d         = lz_blank;
                    cnt_d        = '0;
                    if (!sel_dec) begin
                        bcd_d      = sel_data[23:0];
                        ovf_next_d = |sel_data[31:24];
                        state_d    = UPDATE;
                    end else if (sel_data > DEC_MAX) begin
                        bcd_d      = 24'h999999;
                        ovf_next_d = 1'b1;
                        state_d    = UPDATE;
                    end else begin
                        bcd_d      = '0;
                        bin_d      = sel_data[CONV_BITS-1:0];
                        ovf_next_d = 1'b0;
                        state_d    = CONV;
                    end
                end
            end
            CONV: begin
                bcd_d = {bcd_adj[22:0], bin_q[CONV_BITS-1]};
                bin_d = {bin_q[CONV_BITS-2:0], 1'b0};
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'(CONV_BITS - 1)) state_d = UPDATE;
            end
            UPDATE: begin
                hex_d      = seg;
                overflow_d = ovf_next_q;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            bcd_q        <= '0;
            bin_q        <= '0;
            cnt_q        <= '0;
            ovf_next_q   <= 1'b0;
            lz_q         <= 1'b0;
            hex_q        <= {NUM_DIGITS{SEG_BLANK}};
            overflow_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            bcd_q        <= bcd_d;
            bin_q        <= bin_d;
            cnt_q        <= cnt_d;
            ovf_next_q   <= ovf_next_d;
            lz_q         <= lz_d;
            hex_q        <= hex_d;
            overflow_q   <= overflow_d;
        end
    end

    assign overflow = overflow_q;
    assign HEX0     = hex_q[0];
    assign HEX1     = hex_q[1];
    assign HEX2     = hex_q[2];
    assign HEX3     = hex_q[3];
    assign HEX4     = hex_q[4];
    assign HEX5     = hex_q[5];

endmodule

// File: tb/tb_display_scheduler.sv
// Directed bench for display_scheduler: hex, decimal, saturation, blanking, arbitration
// and mid-conversion reset, each with hand-computed segment codes.
module tb_display_scheduler;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       lz_blank;
    logic       busy;
    logic       overflow;
    logic [6:0] HEX0, HEX1, HEX2, HEX3, HEX4, HEX5;

    int vectors = 0;
    int miscompares = 0;

    localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100;
    localparam logic [6:0] S3 = 7'b0110000, S4 = 7'b0011001, S5 = 7'b0010010;
    localparam logic [6:0] S6 = 7'b0000010, S9 = 7'b0010000, SA = 7'b0001000;
    localparam logic [6:0] SB = 7'b0000011, SC = 7'b1000110, SD = 7'b0100001;
    localparam logic [6:0] SE = 7'b0000110, SF = 7'b0001110, SX = 7'b1111111;

    display_scheduler_if #(.NREQ(2)) bus ();

    display_scheduler #(.NREQ(2), .CONV_BITS(20)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (bus),
        .lz_blank (lz_blank),
        .busy     (busy),
        .overflow (overflow),
        .HEX0     (HEX0),
        .HEX1     (HEX1),
        .HEX2     (HEX2),
        .HEX3     (HEX3),
        .HEX4     (HEX4),
        .HEX5     (HEX5)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_hex(input string tag, input logic [6:0] e5, input logic [6:0] e4,
                           input logic [6:0] e3, input logic [6:0] e2, input logic [6:0] e1,
                           input logic [6:0] e0, input logic eovf);
        chk({tag, " HEX5"}, 32'(HEX5), 32'(e5));
        chk({tag, " HEX4"}, 32'(HEX4), 32'(e4));
        chk({tag, " HEX3"}, 32'(HEX3), 32'(e3));
        chk({tag, " HEX2"}, 32'(HEX2), 32'(e2));
        chk({tag, " HEX1"}, 32'(HEX1), 32'(e1));
        chk({tag, " HEX0"}, 32'(HEX0), 32'(e0));
        chk({tag, " overflow"}, 32'(overflow), 32'(eovf));
    endtask

    // Waits (bounded) for busy to fall; returns edges counted after the accept edge.
    task automatic wait_idle(output int cycles);
        cycles = 1;
        while (busy && cycles < 60) begin
            @(posedge clk);
            #1;
            cycles++;
        end
    endtask

    task automatic send(input string tag, input int idx, input logic [31:0] d,
                        input logic dec, input logic lz, input logic [1:0] exp_ready,
                        input int exp_lat);
        int lat;
        @(negedge clk);
        bus.req_valid      = '0;
        bus.req_valid[idx] = 1'b1;
        bus.req_data[idx]  = d;
        bus.req_dec[idx]   = dec;
        lz_blank           = lz;
        #1;
        chk({tag, " ready"}, 32'(bus.req_ready), 32'(exp_ready));
        @(posedge clk);
        #1;
        bus.req_valid = '0;
        lz_blank      = 1'b0;
        chk({tag, " busy after accept"}, 32'(busy), 32'd1);
        chk({tag, " ready while busy"}, 32'(bus.req_ready), 32'd0);
        @(posedge clk);
        #1;
        wait_idle(lat);
        chk({tag, " latency"}, 32'(lat), 32'(exp_lat));
    endtask

    initial begin
        int cycles;
        int lat;
        logic [1:0] exp_grant;

        rst_n         = 1'b0;
        lz_blank      = 1'b0;
        bus.req_valid = 2'b11;
        bus.req_data  = '0;
        bus.req_dec   = '0;
        #12;
        chk("ready during reset", 32'(bus.req_ready), 32'd0);
        bus.req_valid = '0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk_hex("reset", SX, SX, SX, SX, SX, SX, 1'b0);
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset ready", 32'(bus.req_ready), 32'd0);

        send("hex 00ABCDEF", 0, 32'h00ABCDEF, 1'b0, 1'b0, 2'b01, 1);
        chk_hex("hex 00ABCDEF", SA, SB, SC, SD, SE, SF, 1'b0);
        send("hex 12ABCDEF", 0, 32'h12ABCDEF, 1'b0, 1'b0, 2'b01, 1);
        chk_hex("hex 12ABCDEF", SA, SB, SC, SD, SE, SF, 1'b1);

        send("dec 123456", 1, 32'd123456, 1'b1, 1'b0, 2'b10, 21);
        chk_hex("dec 123456", S1, S2, S3, S4, S5, S6, 1'b0);
        send("dec 1000000", 0, 32'd1000000, 1'b1, 1'b0, 2'b01, 1);
        chk_hex("dec 1000000", S9, S9, S9, S9, S9, S9, 1'b1);
        send("dec 999999", 0, 32'd999999, 1'b1, 1'b0, 2'b01, 21);
        chk_hex("dec 999999", S9, S9, S9, S9, S9, S9, 1'b0);
        send("dec 42 lz", 0, 32'd42, 1'b1, 1'b1, 2'b01, 21);
        chk_hex("dec 42 lz", SX, SX, SX, SX, S4, S2, 1'b0);
        send("dec 42 nolz", 0, 32'd42, 1'b1, 1'b0, 2'b01, 21);
        chk_hex("dec 42 nolz", S0, S0, S0, S0, S4, S2, 1'b0);
        send("hex 0 lz", 0, 32'h0, 1'b0, 1'b1, 2'b01, 1);
        chk_hex("hex 0 lz", SX, SX, SX, SX, SX, S0, 1'b0);
        // Last single grant goes to requester 1 so the tie below starts with requester 0.
        send("dec 0 lz", 1, 32'd0, 1'b1, 1'b1, 2'b10, 21);
        chk_hex("dec 0 lz", SX, SX, SX, SX, SX, S0, 1'b0);

        @(negedge clk);
        bus.req_valid   = 2'b11;
        bus.req_data[0] = 32'd111111;
        bus.req_data[1] = 32'd222222;
        bus.req_dec     = 2'b11;
        #1;
        for (int n = 0; n < 4; n++) begin
            exp_grant = (n % 2 == 0) ? 2'b01 : 2'b10;
            cycles = 0;
            while (bus.req_ready == 2'b00 && cycles < 40) begin
                @(posedge clk);
                #1;
                cycles++;
            end
            chk($sformatf("rr grant %0d", n), 32'(bus.req_ready), 32'(exp_grant));
            @(posedge clk);
            #1;
            chk($sformatf("rr ready busy %0d", n), 32'(bus.req_ready), 32'd0);
            @(posedge clk);
            #1;
            wait_idle(lat);
            chk($sformatf("rr latency %0d", n), 32'(lat), 32'd21);
            if (n % 2 == 0) chk_hex($sformatf("rr value %0d", n), S1, S1, S1, S1, S1, S1, 1'b0);
            else            chk_hex($sformatf("rr value %0d", n), S2, S2, S2, S2, S2, S2, 1'b0);
        end
        @(negedge clk);
        bus.req_valid = '0;

        @(negedge clk);
        bus.req_valid[0] = 1'b1;
        bus.req_data[0]  = 32'd654321;
        bus.req_dec[0]   = 1'b1;
        @(posedge clk);
        #1;
        bus.req_valid = '0;
        repeat (10) @(posedge clk);
        #1;
        chk("mid conv busy", 32'(busy), 32'd1);
        rst_n         = 1'b0;
        bus.req_valid = 2'b01;
        #1;
        chk_hex("mid conv reset", SX, SX, SX, SX, SX, SX, 1'b0);
        chk("mid conv reset busy", 32'(busy), 32'd0);
        chk("mid conv reset ready", 32'(bus.req_ready), 32'd0);
        bus.req_valid = '0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk_hex("after reset idle", SX, SX, SX, SX, SX, SX, 1'b0);
        send("dec 654321", 0, 32'd654321, 1'b1, 1'b0, 2'b01, 21);
        chk_hex("dec 654321", S6, S5, S4, S3, S2, S1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
